// File: rtl/video_frame_scheduler_pkg.sv
// video_frame_scheduler_pkg: shared state encoding, pixel width and width helper
package video_frame_scheduler_pkg;
    localparam int PIXEL_W = 24;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/video_frame_scheduler_if.sv
// video_frame_scheduler_if: frame-buffer read port plus outgoing video stream
interface video_frame_scheduler_if
    import video_frame_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = 19
) ();
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic [PIXEL_W-1:0]    mem_data;
    logic [PIXEL_W-1:0]    video;
    logic                  video_valid;
    logic                  video_ready;
    modport master (output mem_addr, mem_re, video, video_valid, input mem_data, video_ready);
    modport slave  (input mem_addr, mem_re, video, video_valid, output mem_data, video_ready);
endinterface

// File: rtl/video_frame_scheduler_pixel_fifo.sv
// pixel_fifo: first-word-fall-through prefetch FIFO with occupancy count
module pixel_fifo
    import video_frame_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PIXEL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [clog2(DEPTH):0]    count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    // storage and pointers; pushes never arrive when full, pops never when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) mem[wp] <= push_data;
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // head of queue is visible as soon as it is stored
    always_comb begin
        head  = mem[rp];
        empty = count == '0;
        full  = count == (AW+1)'(DEPTH);
    end
endmodule

// File: rtl/video_frame_scheduler.sv
// video_frame_scheduler: raster-order frame-buffer reader feeding the DVI video stream
module video_frame_scheduler
    import video_frame_scheduler_pkg::*;
#(
    parameter int                 WIDTH      = 800,
    parameter int                 HEIGHT     = 600,
    parameter int                 ADDR_WIDTH = 19,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [PIXEL_W-1:0] FILL_COLOR = 24'h000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    source_sel,
    video_frame_scheduler_if.master m,
    output logic                    frame_start,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    underrun
);
    localparam int XW = clog2(WIDTH);
    localparam int YW = clog2(HEIGHT);
    localparam int CW = clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
    logic [1:0]            state;
    logic [1:0]            state_n;
    logic                  src_q;
    logic                  inflight;
    logic                  popped;
    logic                  issue;
    logic                  pop;
    logic                  last_pop;
    logic                  start;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] addr;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [CW-1:0]         count;
    logic [PIXEL_W-1:0]    push_data;
    logic [PIXEL_W-1:0]    head;

    pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIXEL_W)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .head(head), .count(count), .empty(empty), .full(full)
    );

    // credit check, pop detection and frame-start decision
    always_comb begin
        pop      = !empty && m.video_ready;
        last_pop = pop && x == XW'(WIDTH - 1) && y == YW'(HEIGHT - 1);
        issue    = state == ST_RUN && !full && (count + CW'(inflight)) < CW'(FIFO_DEPTH);
        start    = enable && (state == ST_IDLE || last_pop);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // next state: a frame ends only on its final pop, never by enable dropping
    always_comb begin
        state_n = (state == ST_IDLE || last_pop) ? (enable ? ST_RUN : ST_IDLE) :
                  (state == ST_RUN && issue && addr == LAST_ADDR) ? ST_DRAIN : state;
    end

    // outputs: fill mode pushes in the issue cycle, memory mode one cycle later
    always_comb begin
        m.mem_re      = issue && !src_q;
        m.mem_addr    = addr;
        m.video_valid = !empty;
        m.video       = head;
        busy          = state != ST_IDLE;
        push          = inflight || (issue && src_q);
        push_data     = inflight ? m.mem_data : FILL_COLOR;
    end

    // issue address, raster pop position, source latch and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q       <= 1'b0;
            addr        <= '0;
            x           <= '0;
            y           <= '0;
            popped      <= 1'b0;
            inflight    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            inflight    <= m.mem_re;
            frame_start <= start;
            frame_done  <= last_pop;
            underrun    <= underrun || (state != ST_IDLE && popped && m.video_ready && empty);
            if (start) begin
                src_q  <= source_sel;
                addr   <= '0;
                x      <= '0;
                y      <= '0;
                popped <= 1'b0;
            end else begin
                if (issue) addr <= addr + ADDR_WIDTH'(1);
                if (pop) begin
                    popped <= 1'b1;
                    x      <= x == XW'(WIDTH - 1) ? '0 : x + XW'(1);
                    if (x == XW'(WIDTH - 1)) y <= y == YW'(HEIGHT - 1) ? '0 : y + YW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_video_frame_scheduler.sv
// tb_video_frame_scheduler: directed self-checking bench for video_frame_scheduler
module tb_video_frame_scheduler;
    import video_frame_scheduler_pkg::*;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;
    localparam int D  = 4;
    localparam logic [23:0] FILL = 24'hFF0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic source_sel = 1'b0;
    logic frame_start, frame_done, busy, underrun;
    int total = 0;
    int bad = 0;

    int ncyc = 0;
    int re_cnt, fs_cnt, fd_cnt, first_valid, en_cyc;
    logic [23:0] popq[$];
    int popcq[$];
    int addrq[$];
    int fsq[$];
    int fdq[$];

    video_frame_scheduler_if #(.ADDR_WIDTH(AW)) vif ();

    video_frame_scheduler #(
        .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .FIFO_DEPTH(D), .FILL_COLOR(FILL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .source_sel(source_sel), .m(vif),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // synchronous-read memory: data = addr + 0x100000 one cycle after the strobe
    always @(posedge clk) if (vif.mem_re) vif.mem_data <= 24'h100000 + 24'(vif.mem_addr);

    // monitor sampled on the falling edge
    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            if (vif.video_valid && vif.video_ready) begin
                popq.push_back(vif.video);
                popcq.push_back(ncyc);
            end
            if (vif.mem_re) begin
                re_cnt++;
                addrq.push_back(int'(vif.mem_addr));
            end
            if (frame_start) begin
                fs_cnt++;
                fsq.push_back(ncyc);
            end
            if (frame_done) begin
                fd_cnt++;
                fdq.push_back(ncyc);
            end
            if (first_valid < 0 && vif.video_valid) first_valid = ncyc;
        end
    end

    task automatic clear_mon();
        re_cnt = 0; fs_cnt = 0; fd_cnt = 0; first_valid = -1;
        popq.delete(); popcq.delete(); addrq.delete(); fsq.delete(); fdq.delete();
    endtask

    task automatic pulse_enable(input logic sel);
        @(posedge clk); #1;
        source_sel = sel;
        enable = 1'b1;
        en_cyc = ncyc;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && fd_cnt < n; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({vif.mem_addr, vif.mem_re, vif.video_valid, vif.video, frame_start, frame_done, busy, underrun} !== '0)
            begin bad++; $display("FAIL reset_state: got addr=%0h re=%b vv=%b v=%h fs=%b fd=%b busy=%b ur=%b want all 0",
                vif.mem_addr, vif.mem_re, vif.video_valid, vif.video, frame_start, frame_done, busy, underrun); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        clear_mon();
        vif.video_ready = 1'b1;
        pulse_enable(1'b0);
        wait_done(1, 100);
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", fd_cnt); end
        total++; if (fs_cnt !== 1) begin bad++; $display("FAIL basic_start_count: got %0d want 1", fs_cnt); end
        total++; if (re_cnt !== 8) begin bad++; $display("FAIL basic_reads: got %0d want 8", re_cnt); end
        total++; if (popq.size() !== 8) begin bad++; $display("FAIL basic_pops: got %0d want 8", popq.size()); end
        for (int i = 0; i < popq.size(); i++) begin
            total++;
            if (popq[i] !== 24'h100000 + 24'(i)) begin bad++; $display("FAIL basic_pixel[%0d]: got %h want %h", i, popq[i], 24'h100000 + 24'(i)); end
        end
        total++; if (first_valid !== en_cyc + 4) begin bad++; $display("FAIL basic_latency: got %0d want %0d", first_valid - en_cyc - 1, 3); end
        total++;
        if (fdq.size() != 1 || popcq.size() != 8 || fdq[0] !== popcq[7] + 1)
            begin bad++; $display("FAIL basic_done_timing: done pulses=%0d pops=%0d, want done 1 cycle after 8th pop", fdq.size(), popcq.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", busy); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL basic_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        vif.video_ready = 1'b0;
        pulse_enable(1'b0);
        repeat (20) @(posedge clk);
        #1;
        total++; if (re_cnt !== 4) begin bad++; $display("FAIL bp_reads: got %0d want 4", re_cnt); end
        for (int i = 0; i < addrq.size() && i < 4; i++) begin
            total++;
            if (addrq[i] !== i) begin bad++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, addrq[i], i); end
        end
        total++; if (vif.video_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", vif.video_valid); end
        total++; if (vif.video !== 24'h100000) begin bad++; $display("FAIL bp_head: got %h want 100000", vif.video); end
        vif.video_ready = 1'b1;
        wait_done(1, 100);
        total++; if (popq.size() !== 8) begin bad++; $display("FAIL bp_pops: got %0d want 8", popq.size()); end
        for (int i = 0; i < popq.size(); i++) begin
            total++;
            if (popq[i] !== 24'h100000 + 24'(i)) begin bad++; $display("FAIL bp_pixel[%0d]: got %h want %h", i, popq[i], 24'h100000 + 24'(i)); end
        end
        total++; if (re_cnt !== 8) begin bad++; $display("FAIL bp_total_reads: got %0d want 8", re_cnt); end
    endtask

    task automatic test_fill();
        clear_mon();
        pulse_enable(1'b1);
        wait_done(1, 100);
        total++; if (re_cnt !== 0) begin bad++; $display("FAIL fill_reads: got %0d want 0", re_cnt); end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL fill_done: got %0d want 1", fd_cnt); end
        total++; if (popq.size() !== 8) begin bad++; $display("FAIL fill_pops: got %0d want 8", popq.size()); end
        for (int i = 0; i < popq.size(); i++) begin
            total++;
            if (popq[i] !== FILL) begin bad++; $display("FAIL fill_pixel[%0d]: got %h want %h", i, popq[i], FILL); end
        end
        total++; if (first_valid !== en_cyc + 3) begin bad++; $display("FAIL fill_latency: got %0d want %0d", first_valid - en_cyc - 1, 2); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        @(posedge clk); #1;
        source_sel = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 100 && popq.size() < 3; i++) begin @(posedge clk); #1; end
        source_sel = 1'b1;
        for (int i = 0; i < 100 && fd_cnt < 1; i++) begin @(posedge clk); #1; end
        enable = 1'b0;
        wait_done(2, 100);
        total++; if (popq.size() !== 16) begin bad++; $display("FAIL b2b_pops: got %0d want 16", popq.size()); end
        for (int i = 0; i < popq.size(); i++) begin
            total++;
            if (popq[i] !== (i < 8 ? 24'h100000 + 24'(i) : FILL))
                begin bad++; $display("FAIL b2b_pixel[%0d]: got %h want %h", i, popq[i], i < 8 ? 24'h100000 + 24'(i) : FILL); end
        end
        total++; if (re_cnt !== 8) begin bad++; $display("FAIL b2b_reads: got %0d want 8", re_cnt); end
        total++; if (fs_cnt !== 2) begin bad++; $display("FAIL b2b_starts: got %0d want 2", fs_cnt); end
        total++;
        if (fsq.size() != 2 || fdq.size() != 2 || fsq[1] !== fdq[0])
            begin bad++; $display("FAIL b2b_restart: starts=%0d dones=%0d, want second start with first done", fsq.size(), fdq.size()); end
        total++;
        if (popcq.size() != 16 || fdq.size() < 1 || popcq[8] !== fdq[0] + 1)
            begin bad++; $display("FAIL b2b_gap: second frame first pop not 1 cycle after first done (pops=%0d)", popcq.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy: got %b want 0", busy); end
    endtask

    task automatic test_midframe_reset();
        clear_mon();
        pulse_enable(1'b0);
        for (int i = 0; i < 100 && popq.size() < 3; i++) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        total++;
        if ({vif.mem_addr, vif.mem_re, vif.video_valid, vif.video, frame_start, frame_done, busy, underrun} !== '0)
            begin bad++; $display("FAIL mid_reset_async: got addr=%0h re=%b vv=%b v=%h busy=%b want all 0",
                vif.mem_addr, vif.mem_re, vif.video_valid, vif.video, busy); end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (vif.video_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_discard: valid=%b want 0", vif.video_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_idle: busy=%b want 0", busy); end
        clear_mon();
        pulse_enable(1'b0);
        wait_done(1, 100);
        total++; if (addrq.size() < 1 || addrq[0] !== 0) begin bad++; $display("FAIL mid_restart_addr: reads=%0d want first addr 0", addrq.size()); end
        total++; if (popq.size() !== 8) begin bad++; $display("FAIL mid_restart_pops: got %0d want 8", popq.size()); end
        total++; if (popq.size() < 1 || popq[0] !== 24'h100000) begin bad++; $display("FAIL mid_restart_first: want 100000 first"); end
    endtask

    task automatic test_underrun();
        clear_mon();
        pulse_enable(1'b0);
        for (int i = 0; i < 100 && popq.size() < 1; i++) begin @(posedge clk); #1; end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_before: got %b want 0", underrun); end
        force vif.mem_re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        release vif.mem_re;
        repeat (10) @(posedge clk);
        #1;
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set: got %b want 1", underrun); end
        repeat (10) @(posedge clk);
        #1;
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_sticky: got %b want 1", underrun); end
        rst = 1'b1;
        #1;
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_clear: got %b want 0", underrun); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vif.video_ready = 1'b1;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_fill();
        test_back_to_back();
        test_midframe_reset();
        test_underrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
